com_tx_prefetch: RTL and testbench

Peripheral-side transmit buffer that feeds the COM SPI peripheral shifter. It accepts 16-bit words from the local bus side and keeps the next outgoing word pre-loaded in a head register, so the shifter can latch it at each frame start with zero latency. It drives `hold` to tell the controller when no word is ready, and raises a low-water interrupt for the refill path. It sits directly upstream of the peripheral shifter, which drives `peripheral_cipo`.

---
 rtl/com_pkg.sv | 12 +
 rtl/com_tx_prefetch_if.sv | 33 +++
 rtl/com_fifo_mem.sv | 31 +++
 rtl/com_tx_prefetch.sv | 126 ++++++++++++
 tb/tb_com_tx_prefetch.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/com_pkg.sv
// Shared definitions for the COM SPI peripheral transmit path.
//   COM_WORD_W   : SPI frame / word width
//   COM_TX_DEPTH : default storage entries of the transmit prefetch buffer
//   com_word_t   : one transmit word
package com_pkg;

  localparam int COM_WORD_W   = 16;
  localparam int COM_TX_DEPTH = 16;

  typedef logic [COM_WORD_W-1:0] com_word_t;

endpackage

// File: rtl/com_tx_prefetch_if.sv
// Bus and shifter signals of the transmit prefetch buffer.
//   master : bus writer / shifter / configuration side
//   slave  : the prefetch buffer itself
interface com_tx_prefetch_if
  import com_pkg::*;
#(
  parameter int WIDTH   = COM_WORD_W,
  parameter int DEPTH   = COM_TX_DEPTH,
  parameter int LEVEL_W = $clog2(DEPTH + 2)
);
  logic               wr_valid;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_ready;
  logic               shift_load;
  logic [WIDTH-1:0]   shift_data;
  logic               hold;
  logic               clear;
  logic [LEVEL_W-1:0] watermark;
  logic               irq_low;
  logic [LEVEL_W-1:0] level;
  logic               underflow;
  logic               underflow_clr;

  modport master (
    output wr_valid, wr_data, shift_load, clear, watermark, underflow_clr,
    input  wr_ready, shift_data, hold, irq_low, level, underflow
  );

  modport slave (
    input  wr_valid, wr_data, shift_load, clear, watermark, underflow_clr,
    output wr_ready, shift_data, hold, irq_low, level, underflow
  );
endinterface

// File: rtl/com_fifo_mem.sv
// Storage array for the transmit prefetch buffer: synchronous write,
// combinational read (maps to LUT RAM). No reset; validity is tracked
// by the control logic in the top module.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write word
//   raddr_i : read address
//   rdata_o : combinational read word
module com_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/com_tx_prefetch.sv
// Transmit prefetch buffer in front of the COM SPI peripheral shifter.
// Keeps the next outgoing word in a head register so the shifter can take
// it at frame start with no latency; storage behind it holds DEPTH words.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : write handshake, shifter load/data, hold, clear, watermark,
//           low-water irq, level and sticky underflow (see com_tx_prefetch_if)
module com_tx_prefetch
  import com_pkg::*;
#(
  parameter int WIDTH   = COM_WORD_W,
  parameter int DEPTH   = COM_TX_DEPTH,
  parameter int LEVEL_W = $clog2(DEPTH + 2)
) (
  input  logic clk,
  input  logic rst_n,
  com_tx_prefetch_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic               head_valid_q, head_valid_d;
  logic [WIDTH-1:0]   head_q, head_d;
  logic               underflow_q, underflow_d;
  logic               irq_low_q, irq_low_d;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               wr_fire;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_rdata;

  assign level_q = count_q + LEVEL_W'(head_valid_q);
  assign wr_fire = bus.wr_valid && (level_q < LEVEL_W'(DEPTH + 1));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    mem_we       = 1'b0;
    // An empty load is an underflow even when a clear lands in the same cycle.
    underflow_d  = (underflow_q && !bus.underflow_clr) ||
                   (bus.shift_load && !head_valid_q);

    if (bus.clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
      head_d       = '0;
    end else begin
      // Head advances first; storage is never non-empty while head is invalid.
      if (bus.shift_load && head_valid_q) begin
        if (count_q != '0) begin
          head_d   = mem_rdata;
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end else if (wr_fire) begin
          head_d = bus.wr_data;
        end else begin
          head_valid_d = 1'b0;
          head_d       = '0;
        end
      end

      if (wr_fire) begin
        if (!head_valid_q) begin
          head_d       = bus.wr_data;
          head_valid_d = 1'b1;
        end else if (!(bus.shift_load && count_q == '0)) begin
          // Read and write never alias: a full buffer refuses the write.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_d + 1'b1;
        end
      end
    end

    level_d   = count_d + LEVEL_W'(head_valid_d);
    irq_low_d = (level_d <= bus.watermark);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
      underflow_q  <= 1'b0;
      irq_low_q    <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      underflow_q  <= underflow_d;
      irq_low_q    <= irq_low_d;
    end
  end

  com_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign bus.wr_ready   = level_q < LEVEL_W'(DEPTH + 1);
  assign bus.shift_data = head_q;
  assign bus.hold       = !head_valid_q;
  assign bus.level      = level_q;
  assign bus.underflow  = underflow_q;
  assign bus.irq_low    = irq_low_q;

endmodule

// File: tb/tb_com_tx_prefetch.sv
module tb_com_tx_prefetch;
  import com_pkg::*;

  localparam int DEPTH   = COM_TX_DEPTH;
  localparam int LEVEL_W = $clog2(DEPTH + 2);

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  com_tx_prefetch_if #(.WIDTH(COM_WORD_W), .DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) bus ();

  com_tx_prefetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid      = 1'b0;
    bus.shift_load    = 1'b0;
    bus.clear         = 1'b0;
    bus.underflow_clr = 1'b0;
  endtask

  task automatic write_word(input com_word_t d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    idle();
  endtask

  task automatic load();
    bus.shift_load = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wr_data   = '0;
    bus.watermark = LEVEL_W'(2);
    idle();
    #12;
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_hold", bus.hold, 1);
    check("rst_data", bus.shift_data, 0);
    check("rst_irq", bus.irq_low, 1);
    check("rst_level", bus.level, 0);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_underflow", bus.underflow, 0);

    // Two writes, head holds first word until load
    write_word(16'hA503);
    check("w1_hold", bus.hold, 0);
    check("w1_data", bus.shift_data, 16'hA503);
    write_word(16'h1234);
    check("w2_data", bus.shift_data, 16'hA503);
    check("w2_level", bus.level, 2);
    tick(); tick();
    check("w2_data_held", bus.shift_data, 16'hA503);
    load();
    check("ld1_data", bus.shift_data, 16'h1234);
    check("ld1_hold", bus.hold, 0);
    check("ld1_level", bus.level, 1);
    load();
    check("ld2_hold", bus.hold, 1);
    check("ld2_data", bus.shift_data, 0);
    check("ld2_level", bus.level, 0);
    check("ld2_irq", bus.irq_low, 1);

    // Fill to DEPTH+1, refuse extra, drain across pointer wrap
    for (int i = 0; i < DEPTH + 1; i++) write_word(com_word_t'(16'h1000 + i));
    check("full_level", bus.level, DEPTH + 1);
    check("full_wr_ready", bus.wr_ready, 0);
    check("full_irq", bus.irq_low, 0);
    write_word(16'hDEAD);
    check("refused_level", bus.level, DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      check($sformatf("drain_%0d", i), bus.shift_data, 16'h1000 + i);
      load();
    end
    check("drain_hold", bus.hold, 1);
    check("drain_level", bus.level, 0);
    check("drain_data", bus.shift_data, 0);

    // Load with concurrent write on head-only: bypass
    write_word(16'h0001);
    bus.shift_load = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 16'hBEEF;
    tick();
    idle();
    check("byp_data", bus.shift_data, 16'hBEEF);
    check("byp_hold", bus.hold, 0);
    check("byp_level", bus.level, 1);
    load();
    check("byp_empty", bus.hold, 1);

    // Underflow sticky, clear, set-wins
    load();
    check("uf_set", bus.underflow, 1);
    check("uf_head_still_empty", bus.hold, 1);
    tick();
    check("uf_sticky", bus.underflow, 1);
    bus.underflow_clr = 1'b1;
    tick();
    idle();
    check("uf_clr", bus.underflow, 0);
    bus.underflow_clr = 1'b1;
    bus.shift_load    = 1'b1;
    tick();
    idle();
    check("uf_set_wins", bus.underflow, 1);
    bus.underflow_clr = 1'b1;
    tick();
    idle();
    check("uf_clr2", bus.underflow, 0);

    // Watermark crossing and clear with write
    bus.watermark = LEVEL_W'(3);
    for (int i = 0; i < 5; i++) write_word(com_word_t'(16'h0050 + i));
    check("wm_level5", bus.level, 5);
    check("wm_irq5", bus.irq_low, 0);
    load();
    check("wm_level4", bus.level, 4);
    check("wm_irq4", bus.irq_low, 0);
    check("wm_data4", bus.shift_data, 16'h0051);
    load();
    check("wm_level3", bus.level, 3);
    check("wm_irq3", bus.irq_low, 1);
    bus.clear    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h7777;
    tick();
    idle();
    check("clr_level", bus.level, 0);
    check("clr_hold", bus.hold, 1);
    check("clr_data", bus.shift_data, 0);
    check("clr_irq", bus.irq_low, 1);
    tick();
    check("clr_level_after", bus.level, 0);

    // Storage reuse after clear starts from pointer 0
    write_word(16'h00AA);
    write_word(16'h00BB);
    load();
    check("post_clr_data", bus.shift_data, 16'h00BB);

    // Asynchronous reset mid-operation
    write_word(16'h00CC);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", bus.level, 0);
    check("arst_hold", bus.hold, 1);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
